pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the pipelined core.
//  Issues req/ack fetches to instruction memory and presents fetched words to decode.
//  Consumes the BranchUnit decision (NextPCSrc) to redirect the PC and flush the IF/ID and ID/EX stages.
//  Holds fetch state across hazard stalls and keeps a saturating taken-redirect counter.
// PARAMETERS
//  XLEN      32           address/data width
//  RESET_PC  32'h00000000 PC loaded on reset (bits[1:0] must be 0)
//  CNT_W     16           width of TakenCnt
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  BrValid     in   1      a branch/jump is resolved in EX this cycle
//  NextPCSrc   in   1      BranchUnit taken decision; meaningful only when BrValid=1
//  BrTarget    in   XLEN   redirect target from ALU
//  Stall       in   1      hazard unit: freeze PC and IF/ID outputs
//  IMemReq     out  1      fetch request
//  IMemAddr    out  XLEN   fetch address, word aligned
//  IMemAck     in   1      fetch complete, IMemData valid; ignored unless IMemReq=1
//  IMemData    in   32     fetched instruction
//  IfValid     out  1      IfInstr/IfPC hold a valid instruction for decode
//  IfPC        out  XLEN   PC of IfInstr
//  IfInstr     out  32     instruction to decode
//  IfIdFlush   out  1      flush IF/ID (registered, 1-cycle pulse)
//  IdExFlush   out  1      flush ID/EX (registered, 1-cycle pulse)
//  MisalignErr out  1      BrTarget[1:0]!=0 on a taken redirect (1-cycle pulse)
//  TakenCnt    out  CNT_W  number of taken redirects, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state=BOOT, PC=RESET_PC; IMemReq=0, IfValid=0, IfPC=0, IfInstr=0,
//   flushes=0, MisalignErr=0, TakenCnt=0. IMemReq falls immediately, with no clock edge needed.
//  States: BOOT, FETCH, HOLD, DRAIN.
//   BOOT : IMemReq=0; go to FETCH on the next edge.
//   FETCH: IMemReq=1, IMemAddr=PC. Address is stable until ack. Stall does not drop a pending request.
//     Ack&!Stall : IfInstr<=IMemData, IfPC<=PC, IfValid<=1, PC<=PC+4; stay in FETCH.
//     Ack&Stall  : BufInstr<=IMemData, BufPC<=PC, PC<=PC+4; go to HOLD; If* regs hold.
//     !Ack&!Stall: IfValid<=0 (bubble). !Ack&Stall: If* regs hold.
//   HOLD : IMemReq=0. On !Stall: If* <= Buf*, IfValid<=1; go to FETCH.
//   DRAIN: IMemReq=1 with the old address. Wait for ack, discard the data, then go to FETCH (PC is already the target).
//  Redirect = BrValid&NextPCSrc. It is sampled at the edge and overrides Stall and every state action:
//   PC<=BrTarget&~3; IfValid<=0; IfIdFlush<=1; IdExFlush<=1; MisalignErr<=|BrTarget[1:0].
//   TakenCnt<=TakenCnt+1, saturating at all-ones.
//   Next state: FETCH with request pending and no ack -> DRAIN. FETCH with ack the same cycle -> FETCH, data dropped.
//   HOLD -> FETCH, buffer dropped. BOOT -> FETCH. DRAIN -> DRAIN.
//   A second redirect during DRAIN replaces the PC. Both flushes pulse again.
//  BrValid&!NextPCSrc: no effect.
//  Flush and MisalignErr outputs are high exactly one cycle after the redirect edge, then return to 0.
//  PC+4 wraps modulo 2^XLEN (FFFFFFFC -> 00000000). No error is raised.
//  Latency: with a same-cycle ack, a new instruction every cycle. First IfValid appears 2 cycles after reset release.
//  Redirect to target fetch: the request for the target appears in the cycle after the redirect edge (FETCH case).
// TESTING
//  1 Reset release, IMemAck tied 1, data=addr -> IMemAddr 0,4,8..; IfValid from cycle 2; IfPC tracks.
//  2 Ack arrives with Stall=1 for 3 cycles -> HOLD; IMemReq=0; IfInstr unchanged; buffered word appears when Stall falls.
//  3 BrValid=1, NextPCSrc=1, BrTarget=0x100, ack delayed 2 cycles -> DRAIN; old data discarded; next IMemAddr=0x100; flushes pulse once.
//  4 BrValid=1, NextPCSrc=0 -> PC continues +4, no flush, TakenCnt unchanged.
//  5 BrTarget=0x103 taken -> IMemAddr=0x100, MisalignErr 1-cycle pulse.
//  6 PC=FFFFFFFC fetch -> next 0x0. Force TakenCnt to FFFF, redirect -> stays FFFF. Assert rst_n mid-DRAIN -> IMemReq=0 immediately, PC=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer for the pipelined core.
// Issues req/ack fetches, presents fetched words to decode, applies taken
// branch redirects (flushing IF/ID and ID/EX) and counts taken redirects.
module pc_sequencer #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = 32'h0000_0000,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid_i,
    input  logic             next_pc_src_i,
    input  logic [XLEN-1:0]  br_target_i,
    input  logic             stall_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_data_i,
    output logic             if_valid_o,
    output logic [XLEN-1:0]  if_pc_o,
    output logic [31:0]      if_instr_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             misalign_err_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              req_q, req_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic [31:0]       buf_instr_q, buf_instr_d;
    logic              if_id_flush_q, if_id_flush_d;
    logic              id_ex_flush_q, id_ex_flush_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  taken_q, taken_d;

    logic              redirect_s;
    logic              ack_s;
    logic [XLEN-1:0]   target_s;
    logic [XLEN-1:0]   pc_inc_s;

    assign redirect_s = br_valid_i & next_pc_src_i;
    assign ack_s      = imem_ack_i & req_q;
    assign target_s   = br_target_i & ~XLEN'(3);
    assign pc_inc_s   = pc_q + XLEN'(4);

    // Next-state logic: a taken redirect overrides stall and every state action.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        req_d         = req_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        buf_pc_d      = buf_pc_q;
        buf_instr_d   = buf_instr_q;
        if_id_flush_d = 1'b0;
        id_ex_flush_d = 1'b0;
        misalign_d    = 1'b0;
        taken_d       = taken_q;
        if (redirect_s) begin
            pc_d          = target_s;
            if_valid_d    = 1'b0;
            if_id_flush_d = 1'b1;
            id_ex_flush_d = 1'b1;
            misalign_d    = |br_target_i[1:0];
            taken_d       = (taken_q == {CNT_W{1'b1}}) ? taken_q : taken_q + CNT_W'(1);
            case (state_q)
                ST_FETCH: begin
                    if (ack_s) begin
                        state_d = ST_FETCH;
                        addr_d  = target_s;
                        req_d   = 1'b1;
                    end else begin
                        // Outstanding request must complete on its old address.
                        state_d = ST_DRAIN;
                        req_d   = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_DRAIN;
                    req_d   = 1'b1;
                end
                default: begin
                    state_d = ST_FETCH;
                    addr_d  = target_s;
                    req_d   = 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_FETCH;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                end
                ST_FETCH: begin
                    if (ack_s && !stall_i) begin
                        if_instr_d = imem_data_i;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_inc_s;
                        addr_d     = pc_inc_s;
                    end else if (ack_s) begin
                        // Decode is frozen: park the word until stall clears.
                        buf_instr_d = imem_data_i;
                        buf_pc_d    = pc_q;
                        pc_d        = pc_inc_s;
                        req_d       = 1'b0;
                        state_d     = ST_HOLD;
                    end else if (!stall_i) begin
                        if_valid_d = 1'b0;
                    end else begin
                        if_valid_d = if_valid_q;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        if_instr_d = buf_instr_q;
                        if_pc_d    = buf_pc_q;
                        if_valid_d = 1'b1;
                        addr_d     = pc_q;
                        req_d      = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (ack_s) begin
                        // Stale word discarded; pc already holds the target.
                        addr_d  = pc_q;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; async reset drops the request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            req_q         <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= 32'h0000_0000;
            buf_pc_q      <= '0;
            buf_instr_q   <= 32'h0000_0000;
            if_id_flush_q <= 1'b0;
            id_ex_flush_q <= 1'b0;
            misalign_q    <= 1'b0;
            taken_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            req_q         <= req_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
            if_id_flush_q <= if_id_flush_d;
            id_ex_flush_q <= id_ex_flush_d;
            misalign_q    <= misalign_d;
            taken_q       <= taken_d;
        end
    end

    assign imem_req_o     = req_q;
    assign imem_addr_o    = addr_q;
    assign if_valid_o     = if_valid_q;
    assign if_pc_o        = if_pc_q;
    assign if_instr_o     = if_instr_q;
    assign if_id_flush_o  = if_id_flush_q;
    assign id_ex_flush_o  = id_ex_flush_q;
    assign misalign_err_o = misalign_q;
    assign taken_cnt_o    = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a scoreboard of expected (pc, instr)
// pairs is filled as acks are driven and drained as decode sees new words.
module tb_pc_sequencer;

    localparam int unsigned CNT_W = 4;

    logic        clk;
    logic        rst_n;
    logic        br_valid_i;
    logic        next_pc_src_i;
    logic [31:0] br_target_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        misalign_err_o;
    logic [CNT_W-1:0] taken_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = 32'h0;

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid_i(br_valid_i), .next_pc_src_i(next_pc_src_i),
        .br_target_i(br_target_i), .stall_i(stall_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
        .misalign_err_o(misalign_err_o), .taken_cnt_o(taken_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pops the scoreboard whenever decode is presented a new word.
    task automatic monitor();
        logic [63:0] e;
        if (if_valid_o && (!prev_valid || if_pc_o != prev_pc)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {32'h0, if_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", {32'h0, if_pc_o}, {32'h0, e[63:32]});
                check("sb_instr", {32'h0, if_instr_o}, {32'h0, e[31:0]});
            end
        end
        prev_valid = if_valid_o;
        prev_pc    = if_pc_o;
    endtask

    // One clock: drive inputs now, advance past the edge, observe.
    task automatic cyc(input bit ack, input bit stall, input bit brv, input bit src,
                       input logic [31:0] tgt, input bit deliver);
        imem_ack_i    = ack;
        stall_i       = stall;
        br_valid_i    = brv;
        next_pc_src_i = src;
        br_target_i   = tgt;
        imem_data_i   = mem_word(imem_addr_o);
        if (ack && imem_req_o && deliver)
            exp_q.push_back({imem_addr_o, mem_word(imem_addr_o)});
        @(posedge clk);
        #1;
        monitor();
    endtask

    initial begin
        rst_n = 1'b0; imem_ack_i = 1'b0; stall_i = 1'b0; br_valid_i = 1'b0;
        next_pc_src_i = 1'b0; br_target_i = 32'h0; imem_data_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {63'h0, imem_req_o}, 64'h0);
        check("rst_valid", {63'h0, if_valid_o}, 64'h0);
        check("rst_ifpc", {32'h0, if_pc_o}, 64'h0);
        check("rst_flush", {62'h0, if_id_flush_o, id_ex_flush_o}, 64'h0);
        check("rst_taken", {60'h0, taken_cnt_o}, 64'h0);
        rst_n = 1'b1;

        // 1: sequential fetch with same-cycle ack
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_req", {63'h0, imem_req_o}, 64'h1);
        check("t1_valid_c1", {63'h0, if_valid_o}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", {32'h0, imem_addr_o}, 64'(32'(i * 4)));
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("t1_valid", {63'h0, if_valid_o}, 64'h1);
        end

        // 2: ack under stall parks the word in HOLD
        check("t2_addr", {32'h0, imem_addr_o}, 64'h10);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t2_hold_req", {63'h0, imem_req_o}, 64'h0);
        check("t2_hold_pc", {32'h0, if_pc_o}, 64'hC);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t2_hold_req2", {63'h0, imem_req_o}, 64'h0);
        check("t2_hold_instr", {32'h0, if_instr_o}, {32'h0, mem_word(32'hC)});
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t2_resume_addr", {32'h0, imem_addr_o}, 64'h14);
        check("t2_resume_req", {63'h0, imem_req_o}, 64'h1);

        // 3: redirect with pending request -> DRAIN
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
        check("t3_flush", {62'h0, if_id_flush_o, id_ex_flush_o}, 64'h3);
        check("t3_drain_addr", {32'h0, imem_addr_o}, 64'h14);
        check("t3_valid", {63'h0, if_valid_o}, 64'h0);
        check("t3_taken", {60'h0, taken_cnt_o}, 64'h1);
        check("t3_mis", {63'h0, misalign_err_o}, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_flush_end", {62'h0, if_id_flush_o, id_ex_flush_o}, 64'h0);
        check("t3_drain_hold", {32'h0, imem_addr_o}, 64'h14);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_target_addr", {32'h0, imem_addr_o}, 64'h100);
        check("t3_target_req", {63'h0, imem_req_o}, 64'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // 4: not-taken branch has no effect
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1);
        check("t4_addr", {32'h0, imem_addr_o}, 64'h108);
        check("t4_flush", {62'h0, if_id_flush_o, id_ex_flush_o}, 64'h0);
        check("t4_taken", {60'h0, taken_cnt_o}, 64'h1);

        // 5: misaligned target with same-cycle ack (data dropped)
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 1'b0);
        check("t5_addr", {32'h0, imem_addr_o}, 64'h100);
        check("t5_mis", {63'h0, misalign_err_o}, 64'h1);
        check("t5_flush", {62'h0, if_id_flush_o, id_ex_flush_o}, 64'h3);
        check("t5_taken", {60'h0, taken_cnt_o}, 64'h2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t5_mis_end", {63'h0, misalign_err_o}, 64'h0);

        // 6a: PC wraps
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        check("t6_top_addr", {32'h0, imem_addr_o}, 64'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t6_wrap_addr", {32'h0, imem_addr_o}, 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // 6b: taken counter saturates
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
            check("t6_taken", {60'h0, taken_cnt_o}, (i + 4 > 15) ? 64'd15 : 64'(i + 4));
        end

        // 6c: second redirect during DRAIN
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hC0, 1'b0);
        check("t6_redrain_flush", {62'h0, if_id_flush_o, id_ex_flush_o}, 64'h3);
        check("t6_redrain_addr", {32'h0, imem_addr_o}, 64'h40);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_redrain_tgt", {32'h0, imem_addr_o}, 64'hC0);

        // 6d: async reset mid-DRAIN
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
        check("t6_drain_req", {63'h1 & 63'h0, imem_req_o}, 64'h1);
        br_valid_i = 1'b0; next_pc_src_i = 1'b0; imem_ack_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_req", {63'h0, imem_req_o}, 64'h0);
        check("t6_async_taken", {60'h0, taken_cnt_o}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_reset_pc", {32'h0, imem_addr_o}, 64'h0);
        check("t6_reset_req", {63'h0, imem_req_o}, 64'h1);

        check("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
